// File: rtl/regfile_multiport.sv
// regfile_multiport: parametrised multi-read-port register bank with a hardwired
// zero register, optional write-to-read bypass, a switch-input register loaded
// every idle cycle, a display register with update strobe, and a sequenced
// clear after reset that walks the array one entry per cycle.
module regfile_multiport #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int USER_W   = 6,
    parameter int IO_REG   = 30,
    parameter int DISP_REG = 31,
    parameter int BYPASS   = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [USER_W-1:0]          user_number,
    output logic [DATA_W-1:0]          to_display,
    output logic                       disp_upd,
    output logic                       busy
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] IO_ADDR   = ADDR_W'(IO_REG);
    localparam logic [ADDR_W-1:0] DISP_ADDR = ADDR_W'(DISP_REG);

    // Reject configurations that would alias the special registers or the port count.
    generate
        if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
            $fatal(1, "regfile_multiport: NUM_RD must be in 1..4");
        end
        if (IO_REG <= 0 || IO_REG >= DEPTH) begin : g_bad_io_reg
            $fatal(1, "regfile_multiport: IO_REG must be nonzero and below DEPTH");
        end
        if (DISP_REG <= 0 || DISP_REG >= DEPTH) begin : g_bad_disp_reg
            $fatal(1, "regfile_multiport: DISP_REG must be nonzero and below DEPTH");
        end
        if (IO_REG == DISP_REG) begin : g_bad_alias
            $fatal(1, "regfile_multiport: IO_REG and DISP_REG must differ");
        end
        if (USER_W < 1 || USER_W > DATA_W) begin : g_bad_user_w
            $fatal(1, "regfile_multiport: USER_W must be in 1..DATA_W");
        end
    endgenerate

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
    logic                disp_upd_q, disp_upd_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   mem_d [DEPTH];
    logic [DATA_W-1:0]   user_ext;
    logic [ADDR_W-1:0]   rd_a;

    // Zero-extend the switch value to the register width.
    always_comb begin
        user_ext = '0;
        user_ext[USER_W-1:0] = user_number;
    end

    // Next-state: clear walk in CLEAR; write port, switch load and display strobe in IDLE.
    always_comb begin
        state_d    = state_q;
        clr_ptr_d  = clr_ptr_q;
        disp_upd_d = 1'b0;
        mem_d      = mem_q;
        if (!reset) begin
            if (state_q == ST_CLEAR) begin
                mem_d[clr_ptr_q] = '0;
                clr_ptr_d        = clr_ptr_q + 1'b1;
                if (clr_ptr_q == '1) begin
                    state_d = ST_IDLE;
                end
            end else begin
                if (wr_en && wr_addr != '0) begin
                    mem_d[wr_addr] = wr_data;
                end
                // Switch value is applied last so it beats a same-cycle write.
                mem_d[IO_ADDR] = user_ext;
                disp_upd_d     = wr_en && (wr_addr == DISP_ADDR);
            end
        end
    end

    // Control state with synchronous reset that restarts the clear walk.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_CLEAR;
            clr_ptr_q  <= '0;
            disp_upd_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            disp_upd_q <= disp_upd_d;
        end
    end

    // Register array storage; contents are emptied by the clear walk, not by reset.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    // Combinational read ports: zero register, optional bypass, array otherwise.
    always_comb begin
        rd_data = '0;
        rd_a    = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rd_a = rd_addr[i*ADDR_W +: ADDR_W];
            if (state_q == ST_IDLE && rd_a != '0) begin
                if (BYPASS != 0 && wr_en && wr_addr == rd_a && rd_a != IO_ADDR) begin
                    rd_data[i*DATA_W +: DATA_W] = wr_data;
                end else begin
                    rd_data[i*DATA_W +: DATA_W] = mem_q[rd_a];
                end
            end
        end
    end

    // Display and status outputs; the array is masked while the clear walk runs.
    always_comb begin
        to_display = (state_q == ST_IDLE) ? mem_q[DISP_ADDR] : '0;
        disp_upd   = disp_upd_q;
        busy       = (state_q == ST_CLEAR);
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport: one instance with bypass and one without, driven
// by the same inputs and checked every cycle against an array model.
module tb_regfile_multiport;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int UW    = 6;
    localparam int DEPTH = 32;
    localparam int IO    = 30;
    localparam int DISP  = 31;

    logic              clock = 1'b0;
    logic              reset;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*DW-1:0]  rd_data_b, rd_data_n;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic [UW-1:0]     user_number;
    logic [DW-1:0]     to_display_b, to_display_n;
    logic              disp_upd_b, disp_upd_n;
    logic              busy_b, busy_n;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: register contents, edges since reset, expected strobe.
    logic [DW-1:0] mdl_mem [DEPTH];
    int            since = 0;
    bit            seen  = 1'b0;
    bit            mdl_upd = 1'b0;

    regfile_multiport #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .USER_W(UW),
                        .IO_REG(IO), .DISP_REG(DISP), .BYPASS(1)) dut_b (
        .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .user_number(user_number), .to_display(to_display_b),
        .disp_upd(disp_upd_b), .busy(busy_b)
    );

    regfile_multiport #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .USER_W(UW),
                        .IO_REG(IO), .DISP_REG(DISP), .BYPASS(0)) dut_n (
        .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .user_number(user_number), .to_display(to_display_n),
        .disp_upd(disp_upd_n), .busy(busy_n)
    );

    always #5 clock = ~clock;

    task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [DW-1:0] exp_rd(input bit byp, input logic [AW-1:0] a);
        if (since < DEPTH) return '0;
        if (a == '0) return '0;
        if (byp && wr_en && wr_addr == a && int'(a) != IO) return wr_data;
        return mdl_mem[a];
    endfunction

    // Model update on each rising edge from the inputs held across it.
    initial begin
        for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 'x;
        forever begin
            @(posedge clock);
            if (reset) begin
                seen    = 1'b1;
                since   = 0;
                mdl_upd = 1'b0;
            end else if (seen) begin
                if (since < DEPTH) begin
                    since++;
                    mdl_upd = 1'b0;
                    if (since == DEPTH) begin
                        for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
                    end
                end else begin
                    if (wr_en && wr_addr != '0) mdl_mem[wr_addr] = wr_data;
                    mdl_mem[IO] = DW'(user_number);
                    mdl_upd = wr_en && (int'(wr_addr) == DISP);
                end
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    initial begin
        forever begin
            @(negedge clock);
            if (seen) begin
                check("busy_b", DW'(busy_b), DW'(since < DEPTH));
                check("busy_n", DW'(busy_n), DW'(since < DEPTH));
                check("disp_b", to_display_b, (since < DEPTH) ? '0 : mdl_mem[DISP]);
                check("disp_n", to_display_n, (since < DEPTH) ? '0 : mdl_mem[DISP]);
                check("upd_b", DW'(disp_upd_b), DW'(mdl_upd));
                check("upd_n", DW'(disp_upd_n), DW'(mdl_upd));
                for (int i = 0; i < NR; i++) begin
                    check("rd_b", rd_data_b[i*DW +: DW], exp_rd(1'b1, rd_addr[i*AW +: AW]));
                    check("rd_n", rd_data_n[i*DW +: DW], exp_rd(1'b0, rd_addr[i*AW +: AW]));
                end
            end
        end
    end

    // Directed scenarios with literal expectations, then randomized traffic.
    initial begin
        int n;
        logic [AW-1:0] picks [4];
        picks[0] = 5'd0; picks[1] = 5'd7; picks[2] = 5'd30; picks[3] = 5'd31;

        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        user_number = '0; rd_addr = '0;
        repeat (3) tick();
        @(negedge clock);
        check("reset_busy", DW'(busy_b), 32'd1);
        tick();

        // Clear length, with a write attempted throughout the clear.
        reset = 1'b0; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h55;
        n = 0;
        do begin
            tick();
            n++;
        end while (busy_b && n < 100);
        check("clear_len", DW'(n), 32'd32);
        wr_en = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = {AW'(a), AW'(a)};
            @(negedge clock);
            check("zero_sweep", rd_data_b[DW-1:0], 32'h0);
            tick();
        end
        rd_addr = {5'd9, 5'd9};
        @(negedge clock);
        check("write_in_busy", rd_data_n[DW-1:0], 32'h0);
        tick();

        // Write then read on both ports; writes to r0 vanish.
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; rd_addr = {5'd5, 5'd5};
        tick();
        wr_en = 1'b0;
        @(negedge clock);
        check("r5_p0", rd_data_n[DW-1:0], 32'hDEADBEEF);
        check("r5_p1", rd_data_n[2*DW-1:DW], 32'hDEADBEEF);
        tick();
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234; rd_addr = {5'd0, 5'd0};
        @(negedge clock);
        check("r0_same_cycle", rd_data_b[DW-1:0], 32'h0);
        tick();
        wr_en = 1'b0;
        @(negedge clock);
        check("r0_after", rd_data_n[DW-1:0], 32'h0);
        tick();

        // Bypass versus array-only read of a same-cycle write.
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5; rd_addr = {5'd7, 5'd5};
        @(negedge clock);
        check("bypass_on", rd_data_b[2*DW-1:DW], 32'hA5A5A5A5);
        check("bypass_off", rd_data_n[2*DW-1:DW], 32'h0);
        tick();
        wr_en = 1'b0;
        @(negedge clock);
        check("bypass_off_after", rd_data_n[2*DW-1:DW], 32'hA5A5A5A5);
        tick();

        // Switch register load and precedence over a write.
        user_number = 6'h2A; rd_addr = {5'd30, 5'd30};
        @(negedge clock);
        check("io_before", rd_data_b[DW-1:0], 32'h0);
        tick();
        @(negedge clock);
        check("io_loaded", rd_data_b[DW-1:0], 32'h2A);
        tick();
        wr_en = 1'b1; wr_addr = 5'd30; wr_data = 32'hFFFF;
        @(negedge clock);
        check("io_no_bypass", rd_data_b[2*DW-1:DW], 32'h2A);
        tick();
        wr_en = 1'b0;
        @(negedge clock);
        check("io_wins", rd_data_n[DW-1:0], 32'h2A);
        tick();

        // Display update strobe, including a repeat of the same value.
        for (int r = 0; r < 2; r++) begin
            wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'h99;
            tick();
            wr_en = 1'b0;
            @(negedge clock);
            check("disp_val", to_display_b, 32'h99);
            check("disp_pulse", DW'(disp_upd_b), 32'd1);
            tick();
            @(negedge clock);
            check("disp_pulse_end", DW'(disp_upd_n), 32'd0);
            tick();
        end

        // Reset in the middle of a clear restarts the full walk.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (10) tick();
        @(negedge clock);
        check("mid_clear_busy", DW'(busy_b), 32'd1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (busy_b && n < 100);
        check("reclear_len", DW'(n), 32'd32);
        rd_addr = {5'd5, 5'd5};
        @(negedge clock);
        check("r5_cleared", rd_data_b[DW-1:0], 32'h0);
        tick();

        // Randomized traffic, biased toward the special addresses and bypass hits.
        for (int k = 0; k < 3000; k++) begin
            reset       = ($urandom_range(0, 399) == 0);
            wr_en       = $urandom_range(0, 1) == 1;
            wr_addr     = ($urandom_range(0, 1) == 1) ? picks[$urandom_range(0, 3)] : AW'($urandom);
            wr_data     = $urandom;
            user_number = UW'($urandom);
            for (int i = 0; i < NR; i++) begin
                rd_addr[i*AW +: AW] = ($urandom_range(0, 1) == 1) ? wr_addr : AW'($urandom);
            end
            tick();
        end

        reset = 1'b0; wr_en = 1'b0;
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
